bcd_updown_counter_ndigit: RTL and testbench

BCD_UPDOWN_COUNTER_NDIGIT -- requirements
Module: bcd_updown_counter_ndigit

---
 rtl/bcd_updown_counter_ndigit.sv | 84 ++++++++
 tb/tb_bcd_updown_counter_ndigit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_ndigit.sv
// Cascaded N-digit BCD up/down counter with clear, load,
// wrap or saturate at the boundary, and one-cycle wrap pulses.
module bcd_updown_counter_ndigit #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                enable,
    input  logic                sel,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                carry_out,
    output logic                borrow_out,
    output logic                at_max,
    output logic                at_min
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      step_val;
    logic [W-1:0]      load_sat;
    logic [DIGITS:0]   rip;
    logic [DIGITS-1:0] dig_max;
    logic [DIGITS-1:0] dig_min;
    logic              wrap;
    logic              hold_wrap;

    // rip[i] is the carry/borrow arriving at digit i; rip[DIGITS]
    // means every digit rolled over, i.e. the whole counter wraps.
    always_comb begin
        rip      = '0;
        rip[0]   = 1'b1;
        step_val = count;
        load_sat = load_value;
        dig_max  = '0;
        dig_min  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_max[i] = (count[4*i +: 4] == 4'd9);
            dig_min[i] = (count[4*i +: 4] == 4'd0);
            if (load_value[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
            if (rip[i]) begin
                if (!sel) begin
                    step_val[4*i +: 4] = dig_max[i] ? 4'd0
                                       : count[4*i +: 4] + 4'd1;
                end else begin
                    step_val[4*i +: 4] = dig_min[i] ? 4'd9
                                       : count[4*i +: 4] - 4'd1;
                end
            end
            rip[i+1] = rip[i] & (sel ? dig_min[i] : dig_max[i]);
        end
    end

    assign wrap      = rip[DIGITS];
    assign hold_wrap = wrap & SATURATE;
    assign at_max    = &dig_max;
    assign at_min    = &dig_min;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            count      <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load) begin
                count <= load_sat;
            end else if (enable && !hold_wrap) begin
                count      <= step_val;
                carry_out  <= wrap & ~sel;
                borrow_out <= wrap & sel;
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_ndigit.sv
// Scoreboard bench: three counter variants driven in lockstep and
// checked against an integer model of the counting rules.
module tb_bcd_updown_counter_ndigit;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        enable = 1'b0;
    logic        sel = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic [7:0]  lv8;

    logic [7:0]  cnt_2w, cnt_2s;
    logic [15:0] cnt_4w;
    logic        cy_2w, cy_2s, cy_4w;
    logic        bw_2w, bw_2s, bw_4w;
    logic        mx_2w, mx_2s, mx_4w;
    logic        mn_2w, mn_2s, mn_4w;

    assign lv8 = load_value[7:0];

    always #5 clk = ~clk;

    bcd_updown_counter_ndigit #(.DIGITS(2), .SATURATE(1'b0)) u_2w (
        .clk(clk), .reset_p(reset_p), .enable(enable), .sel(sel),
        .clear(clear), .load(load), .load_value(lv8),
        .count(cnt_2w), .carry_out(cy_2w), .borrow_out(bw_2w),
        .at_max(mx_2w), .at_min(mn_2w));

    bcd_updown_counter_ndigit #(.DIGITS(2), .SATURATE(1'b1)) u_2s (
        .clk(clk), .reset_p(reset_p), .enable(enable), .sel(sel),
        .clear(clear), .load(load), .load_value(lv8),
        .count(cnt_2s), .carry_out(cy_2s), .borrow_out(bw_2s),
        .at_max(mx_2s), .at_min(mn_2s));

    bcd_updown_counter_ndigit #(.DIGITS(4), .SATURATE(1'b0)) u_4w (
        .clk(clk), .reset_p(reset_p), .enable(enable), .sel(sel),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_4w), .carry_out(cy_4w), .borrow_out(bw_4w),
        .at_max(mx_4w), .at_min(mn_4w));

    typedef struct {
        logic [15:0] cnt [3];
        bit          cy  [3];
        bit          bw  [3];
        bit          mx  [3];
        bit          mn  [3];
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   total = 0;
    int   bad = 0;

    int   val [3];
    bit   pcy [3];
    bit   pbw [3];
    int   ndig [3] = '{2, 2, 4};
    bit   nsat [3] = '{1'b0, 1'b1, 1'b0};

    function automatic int maxv(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic [15:0] tobcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clampv(input logic [15:0] lv, input int d);
        int r = 0;
        int p = 1;
        int n;
        for (int i = 0; i < d; i++) begin
            n = int'((lv >> (4 * i)) & 16'hF);
            if (n > 9) n = 9;
            r = r + n * p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic mstep(input int k, input bit en, input bit sl,
                         input bit clr, input bit ld,
                         input logic [15:0] lv);
        int top = maxv(ndig[k]);
        pcy[k] = 1'b0;
        pbw[k] = 1'b0;
        if (clr) begin
            val[k] = 0;
        end else if (ld) begin
            val[k] = clampv(lv, ndig[k]);
        end else if (en && !sl) begin
            if (val[k] == top) begin
                if (!nsat[k]) begin
                    val[k] = 0;
                    pcy[k] = 1'b1;
                end
            end else begin
                val[k] = val[k] + 1;
            end
        end else if (en && sl) begin
            if (val[k] == 0) begin
                if (!nsat[k]) begin
                    val[k] = top;
                    pbw[k] = 1'b1;
                end
            end else begin
                val[k] = val[k] - 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            val[k] = 0;
            pcy[k] = 1'b0;
            pbw[k] = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.cnt[k] = tobcd(val[k]);
            e.cy[k]  = pcy[k];
            e.bw[k]  = pbw[k];
            e.mx[k]  = (val[k] == maxv(ndig[k]));
            e.mn[k]  = (val[k] == 0);
        end
        q.push_back(e);
        ->mon_ev;
    endtask

    function automatic void chk(input string nm, input int k,
                                input logic [15:0] act,
                                input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h",
                     nm, k, $time, act, exp);
        end
    endfunction

    // Monitor: pop one expectation per sample event and compare.
    initial begin
        exp_t e;
        logic [15:0] ac [3];
        logic        acy [3];
        logic        abw [3];
        logic        amx [3];
        logic        amn [3];
        forever begin
            @(mon_ev);
            ac[0] = {8'h00, cnt_2w};
            ac[1] = {8'h00, cnt_2s};
            ac[2] = cnt_4w;
            acy   = '{cy_2w, cy_2s, cy_4w};
            abw   = '{bw_2w, bw_2s, bw_4w};
            amx   = '{mx_2w, mx_2s, mx_4w};
            amn   = '{mn_2w, mn_2s, mn_4w};
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("count",  k, ac[k], e.cnt[k]);
                    chk("carry",  k, 16'(acy[k]), 16'(e.cy[k]));
                    chk("borrow", k, 16'(abw[k]), 16'(e.bw[k]));
                    chk("at_max", k, 16'(amx[k]), 16'(e.mx[k]));
                    chk("at_min", k, 16'(amn[k]), 16'(e.mn[k]));
                end
            end
        end
    end

    // One clock of stimulus; optionally pulse reset between edges.
    task automatic cyc(input bit en, input bit sl, input bit clr,
                       input bit ld, input logic [15:0] lv,
                       input bit rp);
        @(negedge clk);
        enable     = en;
        sel        = sl;
        clear      = clr;
        load       = ld;
        load_value = lv;
        if (rp) begin
            #2;
            reset_p = 1'b1;
            #1;
            model_reset();
            push_exp();
            reset_p = 1'b0;
        end
        for (int k = 0; k < 3; k++) mstep(k, en, sl, clr, ld, lv);
        @(posedge clk);
        #1;
        push_exp();
    endtask

    initial begin
        model_reset();
        #1;
        push_exp();
        @(negedge clk);
        reset_p = 1'b0;

        for (int i = 0; i < 100; i++) cyc(1, 0, 0, 0, 16'h0, 0);

        cyc(0, 0, 1, 0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 0, 16'h0, 0);

        cyc(0, 0, 0, 1, 16'h003C, 0);
        cyc(1, 1, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 1, 16'h0009, 0);

        cyc(0, 0, 0, 1, 16'h0045, 0);
        cyc(1, 0, 1, 1, 16'h0045, 0);

        cyc(0, 0, 0, 1, 16'h9999, 0);
        cyc(1, 0, 0, 0, 16'h0, 1);
        cyc(0, 0, 0, 0, 16'h0, 0);

        cyc(0, 0, 0, 1, 16'h0999, 0);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 1, 16'h9999, 0);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 0, 16'h0, 0);

        cyc(0, 0, 1, 0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(0, 0, 0, 0, 16'h0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 8,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0,
                16'($urandom),
                $urandom_range(0, 49) == 0);
        end

        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
